memory_data_ctrl: RTL and testbench
===================================

# memory_data_ctrl

Data-memory controller for the core's load/store stage, the parametrised successor to the current word-indexed data memory. It takes byte addresses with RISC-V funct3-style widths. It handles sub-word accesses on any byte lane and supports a valid/ready request handshake with registered responses. Accesses that cross a word boundary are either split into two word cycles or reported as errors, selected by parameter.

## Interface
- `ADDR_W`, 12: word-index bits; depth = 2^ADDR_W 32-bit words; byte span = 2^(ADDR_W+2).
- `SPLIT_EN`, 1: 1 = word-crossing accesses are split into two cycles; 0 = word-crossing accesses return `resp_err`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_width`  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu; 011/110/111 are illegal.
- `req_wdata`  in  32  store data, LSB-justified.
- `resp_valid`  out  1  one-cycle pulse per accepted request.
- `resp_rdata`  out  32  load result, extended per width; 0 for stores and errors.
- `resp_err`  out  1  qualifies `resp_valid`; illegal width, out-of-range address, or crossing access with `SPLIT_EN`=0.

## Operation
- Address decode: `off` = `addr[1:0]`; `idx` = `addr[ADDR_W+1:2]`; size = 1, 2 or 4 bytes.
- Out of range: any of `addr[31:ADDR_W+2]` is nonzero.
- Crossing: `off` + size > 4. A non-crossing access completes in one cycle even if it is not naturally aligned (e.g. half at `off`=1 uses lanes 1–2).
- Error detection happens at acceptance; an erroring request writes nothing.
- Split-case range check: if `idx` = 2^ADDR_W−1, the second word is out of range → error, nothing written. There is no wrap to word 0.
- Store: only the addressed byte lanes are written; other lanes keep their value. Store data byte k goes to lane (`off`+k).
  - Split store: cycle 1 writes lanes `off`..3 of word `idx`; cycle 2 writes lanes 0..(`off`+size−5) of word `idx`+1.
- Load: bytes are taken from the addressed lanes, LSB first.
  - Split load: low bytes come from `idx`, high bytes from `idx`+1.
  - Signed widths (b, h) sign-extend from the top loaded bit; bu/hu zero-extend.
- FSM:
  - IDLE: `req_ready`=1. An accepted non-crossing or erroring request → IDLE. An accepted crossing request with `SPLIT_EN`=1 → SECOND.
  - SECOND: `req_ready`=0; performs the second word access; → IDLE.
- Request capture: the request is latched on acceptance. Inputs are ignored while `req_ready`=0.
- Single port: one memory access per cycle. The controller never needs read-modify-write; the memory supports byte write enables.
- Memory contents are not affected by `rst`.

## Timing
- Reset values: `req_ready`=0 while `rst`=1 and 1 from the first cycle after; `resp_valid`=0, `resp_err`=0, `resp_rdata`=0; FSM = IDLE.
- Handshake: a request is accepted on an edge where `req_valid`&`req_ready` is 1.
- Latency:
  - Accepted at edge T, non-crossing or erroring → `resp_valid` high for the cycle after T (registered, 1 cycle).
  - Split → `resp_valid` after edge T+1 (2 cycles).
- Throughput: back-to-back non-crossing requests are accepted every cycle.
- Read-after-write: a load accepted the cycle after a store to the same lanes returns the new data.
- Response has no backpressure: the consumer must take `resp_valid` the cycle it is high.
- `resp_rdata`/`resp_err` are valid only with `resp_valid`; they return to 0 when it drops.
- Reset mid-split: the second half is dropped, the first-half write persists, and no response is produced.

## Test plan
- Store w 0x11223344 @0x10, then lb @0x13 → 0x00000011; lh @0x12 → 0x00001122; lw @0x10 → 0x11223344, each 1 cycle after acceptance.
- Store b 0x80 @0x21 over word 0xFFFFFFFF → word 0xFFFF80FF; lb @0x21 → 0xFFFFFF80; lbu → 0x00000080.
- `SPLIT_EN`=1:
  - Pre-fill 0x40 and 0x44 with 0. Store w 0xAABBCCDD @0x42 → word 0x40 = 0xCCDD0000, word 0x44 = 0x0000AABB; `req_ready` low 1 cycle.
  - lw @0x42 → 0xAABBCCDD, `resp_valid` 2 cycles after acceptance.
- `SPLIT_EN`=0: lh @0x43 → `resp_err`=1, `resp_rdata`=0. Store w @0x41 → `resp_err`=1 and memory unchanged.
- Errors:
  - `req_width`=011 → `resp_err`.
  - Address 0x4000 with `ADDR_W`=12 → `resp_err`.
  - lw @0x3FFE (last word, crossing) → `resp_err`, nothing written.
- Assert `rst` in the SECOND cycle of store w 0x01020304 @0x42 → only lanes 2–3 of 0x40 updated, no `resp_valid`; `req_ready` = 1 the cycle after `rst` falls.

Source files
------------

// File: rtl/memory_data_ctrl.sv
// rtl/memory_data_ctrl.sv - byte-addressed data memory controller with sub-word and split access
//
// Purpose: load/store data memory for the core. It takes byte addresses with
// funct3-style widths, accepts one request per cycle on a valid/ready handshake
// and returns a registered response one cycle after acceptance. An access that
// crosses a word boundary is either split over two word cycles (SPLIT_EN=1) or
// rejected with resp_err (SPLIT_EN=0).
//
// Parameters:
//   ADDR_W    word-index bits; depth is 2^ADDR_W 32-bit words (ADDR_W <= 29)
//   SPLIT_EN  1 = split word-crossing accesses, 0 = report them as errors
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset (memory contents are kept)
//   req_valid   request present
//   req_ready   request can be accepted this cycle
//   req_we      1 = store, 0 = load
//   req_addr    byte address
//   req_width   000 b, 001 h, 010 w, 100 bu, 101 hu; others illegal
//   req_wdata   store data, LSB-justified
//   resp_valid  one-cycle pulse per accepted request
//   resp_rdata  extended load data; 0 for stores, errors and idle cycles
//   resp_err    error flag, qualified by resp_valid

module memory_data_ctrl #(
  parameter int ADDR_W   = 12,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_width,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SECOND = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Byte-lane mask of an access of the given size, before shifting to its offset.
  function automatic logic [7:0] size_mask(input logic [2:0] size);
    case (size)
      3'd1:    size_mask = 8'h01;
      3'd2:    size_mask = 8'h03;
      3'd4:    size_mask = 8'h0F;
      default: size_mask = 8'h00;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Incoming request decode
  // ---------------------------------------------------------------------------
  logic [1:0]        req_off;
  logic [ADDR_W-1:0] req_idx;
  logic [2:0]        req_size;
  logic              req_width_ok;
  logic              req_oor;
  logic              req_cross;
  logic              req_err;
  logic              req_accept;
  logic [7:0]        req_be8;
  logic [63:0]       req_data64;

  assign req_off = req_addr[1:0];
  assign req_idx = req_addr[ADDR_W+1:2];

  always_comb begin
    req_size     = 3'd0;
    req_width_ok = 1'b1;
    case (req_width)
      3'b000, 3'b100: req_size = 3'd1;
      3'b001, 3'b101: req_size = 3'd2;
      3'b010:         req_size = 3'd4;
      default:        req_width_ok = 1'b0;
    endcase
  end

  assign req_oor   = |(req_addr >> (ADDR_W + 2));
  assign req_cross = ({1'b0, req_off} + req_size) > 3'd4;

  // A crossing access on the last word would need a word that does not exist;
  // it is rejected rather than wrapped to word 0.
  assign req_err = !req_width_ok || req_oor ||
                   (req_cross && (!SPLIT_EN || (req_idx == LAST_IDX)));

  assign req_accept = req_valid && req_ready;

  // Lanes and data over a two-word window: the low half belongs to word idx,
  // the high half to word idx+1 (only non-zero for crossing accesses).
  assign req_be8    = size_mask(req_size) << req_off;
  assign req_data64 = {32'd0, req_wdata} << {req_off, 3'b000};

  // ---------------------------------------------------------------------------
  // Request capture and response state
  // ---------------------------------------------------------------------------
  logic              we_q;
  logic [2:0]        width_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] idx_q;
  logic [3:0]        be_hi_q;
  logic [31:0]       wdata_hi_q;
  logic              split_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [31:0]       lo_q;
  logic [31:0]       mem_rd_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_accept && !req_err && req_cross) begin
          state_d = S_SECOND;
        end
      end
      S_SECOND: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs (handshake and the single memory port)
  logic [ADDR_W-1:0] mem_idx;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;

  always_comb begin
    req_ready = 1'b0;
    mem_idx   = req_idx;
    mem_be    = 4'b0000;
    mem_wdata = req_data64[31:0];
    case (state_q)
      S_IDLE: begin
        req_ready = !rst;
        if (req_accept && req_we && !req_err) begin
          mem_be = req_be8[3:0];
        end
      end
      S_SECOND: begin
        mem_idx   = idx_q + 1'b1;
        mem_wdata = wdata_hi_q;
        // Reset during the second half drops it; the first half already landed.
        if (we_q && !rst) begin
          mem_be = be_hi_q;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory: one access per cycle, byte write enables, read-first output register
  // ---------------------------------------------------------------------------
  logic [31:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_be[k]) begin
        mem[mem_idx][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
    end
    mem_rd_q <= mem[mem_idx];
  end

  // ---------------------------------------------------------------------------
  // Capture and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q         <= 1'b0;
      width_q      <= 3'b000;
      off_q        <= 2'b00;
      idx_q        <= '0;
      be_hi_q      <= 4'b0000;
      wdata_hi_q   <= 32'd0;
      split_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      lo_q         <= 32'd0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_accept) begin
            we_q         <= req_we;
            width_q      <= req_width;
            off_q        <= req_off;
            idx_q        <= req_idx;
            be_hi_q      <= req_be8[7:4];
            wdata_hi_q   <= req_data64[63:32];
            split_q      <= req_cross && !req_err;
            resp_err_q   <= req_err;
            resp_valid_q <= req_err || !req_cross;
          end
        end
        S_SECOND: begin
          // mem_rd_q holds word idx from the first cycle; keep it as the low half.
          lo_q         <= mem_rd_q;
          resp_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Load formatting: align the addressed bytes to bit 0, then extend
  // ---------------------------------------------------------------------------
  logic [31:0] ld_lo;
  logic [31:0] ld_raw;
  logic [31:0] ld_ext;

  assign ld_lo  = split_q ? lo_q : mem_rd_q;
  assign ld_raw = 32'({mem_rd_q, ld_lo} >> {off_q, 3'b000});

  always_comb begin
    case (width_q[1:0])
      2'b00:   ld_ext = {{24{!width_q[2] && ld_raw[7]}}, ld_raw[7:0]};
      2'b01:   ld_ext = {{16{!width_q[2] && ld_raw[15]}}, ld_raw[15:0]};
      default: ld_ext = ld_raw;
    endcase
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_valid_q && resp_err_q;
  assign resp_rdata = (resp_valid_q && !resp_err_q && !we_q) ? ld_ext : 32'd0;

endmodule

// File: tb/tb_memory_data_ctrl.sv
// tb/tb_memory_data_ctrl.sv - directed self-checking bench for memory_data_ctrl

module tb_memory_data_ctrl;

  localparam logic [2:0] W_B   = 3'b000;
  localparam logic [2:0] W_H   = 3'b001;
  localparam logic [2:0] W_W   = 3'b010;
  localparam logic [2:0] W_BAD = 3'b011;
  localparam logic [2:0] W_BU  = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_width;
  logic [31:0] req_wdata;

  // a: SPLIT_EN=1, b: SPLIT_EN=0; both see the same request stream.
  logic        rdy_a, vld_a, err_a;
  logic [31:0] rd_a;
  logic        rdy_b, vld_b, err_b;
  logic [31:0] rd_b;

  int n_checks = 0;
  int n_fail   = 0;

  int          lat_a, lat_b;
  logic [31:0] data_a, data_b;
  logic        e_a, e_b;
  logic        rdy1_a, rdy2_a;

  always #5 clk = ~clk;

  memory_data_ctrl #(.ADDR_W(12), .SPLIT_EN(1'b1)) u_dut_split (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_a),
    .req_we(req_we), .req_addr(req_addr), .req_width(req_width), .req_wdata(req_wdata),
    .resp_valid(vld_a), .resp_rdata(rd_a), .resp_err(err_a)
  );

  memory_data_ctrl #(.ADDR_W(12), .SPLIT_EN(1'b0)) u_dut_nosplit (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_b),
    .req_we(req_we), .req_addr(req_addr), .req_width(req_width), .req_wdata(req_wdata),
    .resp_valid(vld_b), .resp_rdata(rd_b), .resp_err(err_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one request, then watch up to three cycles for each DUT's first response.
  // A latency of 0 means no response arrived inside the window.
  task automatic xact(input logic we, input logic [2:0] w, input logic [31:0] addr,
                      input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_width = w;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat_a = 0; lat_b = 0; data_a = 32'd0; data_b = 32'd0; e_a = 1'b0; e_b = 1'b0;
    rdy1_a = 1'b0; rdy2_a = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (c == 1) rdy1_a = rdy_a;
      if (c == 2) rdy2_a = rdy_a;
      if (vld_a && lat_a == 0) begin lat_a = c; data_a = rd_a; e_a = err_a; end
      if (vld_b && lat_b == 0) begin lat_b = c; data_b = rd_b; e_b = err_b; end
    end
  endtask

  task automatic load_a(input string tag, input logic [2:0] w, input logic [31:0] addr,
                        input logic [31:0] exp, input int exp_lat);
    xact(1'b0, w, addr, 32'd0);
    check_eq({tag, "_data"}, data_a, exp);
    check_eq({tag, "_lat"}, lat_a, exp_lat);
    check_eq({tag, "_err"}, {31'd0, e_a}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 32'd0; req_width = 3'd0; req_wdata = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'd0, rdy_a}, 32'd0);
    check_eq("rst_valid", {31'd0, vld_a}, 32'd0);
    check_eq("rst_rdata", rd_a, 32'd0);
    check_eq("rst_err", {31'd0, err_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst_ready", {31'd0, rdy_a}, 32'd1);

    // Word store, then sub-word loads from it
    xact(1'b1, W_W, 32'h10, 32'h11223344);
    check_eq("sw10_lat", lat_a, 32'd1);
    check_eq("sw10_rdata", data_a, 32'd0);
    load_a("lb13", W_B, 32'h13, 32'h00000011, 1);
    load_a("lh12", W_H, 32'h12, 32'h00001122, 1);
    load_a("lw10", W_W, 32'h10, 32'h11223344, 1);
    load_a("lh11", W_H, 32'h11, 32'h00002233, 1);

    // Byte store into an all-ones word, signed and unsigned byte loads
    xact(1'b1, W_W, 32'h20, 32'hFFFFFFFF);
    xact(1'b1, W_B, 32'h21, 32'h00000080);
    load_a("lw20", W_W, 32'h20, 32'hFFFF80FF, 1);
    load_a("lb21", W_B, 32'h21, 32'hFFFFFF80, 1);
    load_a("lbu21", W_BU, 32'h21, 32'h00000080, 1);

    // Store then load on consecutive cycles
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_width = W_B; req_addr = 32'h10; req_wdata = 32'h0000005A;
    @(posedge clk);
    #1;
    check_eq("b2b_store_valid", {31'd0, vld_a}, 32'd1);
    @(negedge clk);
    req_we = 1'b0; req_width = W_W; req_addr = 32'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("b2b_load_valid", {31'd0, vld_a}, 32'd1);
    check_eq("b2b_raw_data", rd_a, 32'h1122335A);

    // Crossing accesses: split on a, rejected on b
    xact(1'b1, W_W, 32'h40, 32'd0);
    xact(1'b1, W_W, 32'h44, 32'd0);
    xact(1'b1, W_W, 32'h42, 32'hAABBCCDD);
    check_eq("split_sw_lat", lat_a, 32'd2);
    check_eq("split_sw_err", {31'd0, e_a}, 32'd0);
    check_eq("split_ready_c1", {31'd0, rdy1_a}, 32'd0);
    check_eq("split_ready_c2", {31'd0, rdy2_a}, 32'd1);
    check_eq("nosplit_sw_err", {31'd0, e_b}, 32'd1);
    check_eq("nosplit_sw_lat", lat_b, 32'd1);
    xact(1'b0, W_W, 32'h40, 32'd0);
    check_eq("split_w40", data_a, 32'hCCDD0000);
    check_eq("nosplit_w40", data_b, 32'h00000000);
    xact(1'b0, W_W, 32'h44, 32'd0);
    check_eq("split_w44", data_a, 32'h0000AABB);
    check_eq("nosplit_w44", data_b, 32'h00000000);
    load_a("split_lw42", W_W, 32'h42, 32'hAABBCCDD, 2);
    check_eq("nosplit_lw42_err", {31'd0, e_b}, 32'd1);
    check_eq("nosplit_lw42_data", data_b, 32'd0);
    load_a("split_lh43", W_H, 32'h43, 32'hFFFFBBCC, 2);
    check_eq("nosplit_lh43_err", {31'd0, e_b}, 32'd1);
    check_eq("nosplit_lh43_data", data_b, 32'd0);
    xact(1'b1, W_W, 32'h41, 32'h55555555);
    check_eq("nosplit_sw41_err", {31'd0, e_b}, 32'd1);
    xact(1'b0, W_W, 32'h40, 32'd0);
    check_eq("split_w40_after41", data_a, 32'h55555500);
    check_eq("nosplit_w40_after41", data_b, 32'h00000000);
    xact(1'b0, W_W, 32'h44, 32'd0);
    check_eq("split_w44_after41", data_a, 32'h0000AA55);
    check_eq("nosplit_w44_after41", data_b, 32'h00000000);

    // Error cases
    xact(1'b0, W_BAD, 32'h10, 32'd0);
    check_eq("badwidth_err", {31'd0, e_a}, 32'd1);
    check_eq("badwidth_data", data_a, 32'd0);
    check_eq("badwidth_lat", lat_a, 32'd1);
    xact(1'b0, W_W, 32'h4000, 32'd0);
    check_eq("oor_err", {31'd0, e_a}, 32'd1);
    xact(1'b1, W_W, 32'h3FFC, 32'd0);
    xact(1'b1, W_W, 32'h0, 32'd0);
    xact(1'b0, W_W, 32'h3FFE, 32'd0);
    check_eq("last_lw_err", {31'd0, e_a}, 32'd1);
    check_eq("last_lw_lat", lat_a, 32'd1);
    xact(1'b1, W_W, 32'h3FFE, 32'h12345678);
    check_eq("last_sw_err", {31'd0, e_a}, 32'd1);
    load_a("last_word_kept", W_W, 32'h3FFC, 32'h00000000, 1);
    load_a("no_wrap_word0", W_W, 32'h0, 32'h00000000, 1);

    // Reset during the second half of a split store
    xact(1'b1, W_W, 32'h40, 32'd0);
    xact(1'b1, W_W, 32'h44, 32'd0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_width = W_W; req_addr = 32'h42; req_wdata = 32'h01020304;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("midrst_second", {31'd0, rdy_a}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_no_resp", {31'd0, vld_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_ready", {31'd0, rdy_a}, 32'd1);
    check_eq("midrst_no_resp2", {31'd0, vld_a}, 32'd0);
    load_a("midrst_w40", W_W, 32'h40, 32'h03040000, 1);
    load_a("midrst_w44", W_W, 32'h44, 32'h00000000, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
